// File: rtl/bcs_pkg.sv
// Shared definitions for the serial bit-compare-slice controller.
package bcs_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Bits needed to index WIDTH positions; the counter uses one more bit so it can hold WIDTH itself.
  function automatic int clog2_w(input int w);
    int r;
    r = 0;
    while ((1 << r) < w) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcs_serial_compare_ctrl_if.sv
// Requester-side bus: start/operands in, busy/done/result out.
interface bcs_serial_compare_ctrl_if
  import bcs_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int CW = clog2_w(WIDTH) + 1;

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [CW-1:0]    bits_used;

  modport master (
    output start, a_in, b_in,
    input  busy, done, eq, gt, lt, bits_used
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, eq, gt, lt, bits_used
  );
endinterface

// File: rtl/bcs_cell.sv
// One bit-compare slice: folds a single bit pair into the running equal/greater state.
module bcs_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic e0_i,
  input  logic g0_i,
  output logic e1_o,
  output logic g1_o
);
  assign e1_o = e0_i & ~(a_i ^ b_i);
  assign g1_o = g0_i | (e0_i & a_i & ~b_i);
endmodule

// File: rtl/bcs_serial_compare_ctrl.sv
// MSB-first serial magnitude comparator: one bcs_cell stepped over the operands with registered e/g.
module bcs_serial_compare_ctrl
  import bcs_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  bcs_serial_compare_ctrl_if.slave bus
);
  localparam int IW = clog2_w(WIDTH);
  localparam int CW = IW + 1;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             e_q;
  logic             g_q;
  logic             e_d;
  logic             g_d;
  logic             last_bit;

  logic             busy_q;
  logic             done_q;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;
  logic [CW-1:0]    bits_q;

  bcs_cell u_cell (
    .a_i  (a_q[idx_q]),
    .b_i  (b_q[idx_q]),
    .e0_i (e_q),
    .g0_i (g_q),
    .e1_o (e_d),
    .g1_o (g_d)
  );

  assign cnt_d    = (cnt_q == CW'(WIDTH)) ? cnt_q : cnt_q + CW'(1);
  // Once e drops the remaining lower bits cannot change the outcome.
  assign last_bit = (idx_q == '0) || (EARLY_EXIT && !e_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      bits_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            idx_q   <= IW'(WIDTH - 1);
            cnt_q   <= '0;
            e_q     <= 1'b1;
            g_q     <= 1'b0;
          end
        end
        S_RUN: begin
          e_q   <= e_d;
          g_q   <= g_d;
          cnt_q <= cnt_d;
          if (idx_q != '0) idx_q <= idx_q - IW'(1);
          // Result registers take the slice output directly so they match e/g on DONE entry.
          if (last_bit) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            eq_q    <= e_d;
            gt_q    <= g_d;
            lt_q    <= ~e_d & ~g_d;
            bits_q  <= cnt_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.bits_used = bits_q;

endmodule

// File: tb/tb_bcs_serial_compare_ctrl.sv
// Drives an early-exit and a full-length comparator with identical requests and checks both cycle by cycle.
module tb_bcs_serial_compare_ctrl;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  int         total = 0;
  int         bad = 0;
  logic [6:0] prev_ee;
  logic [6:0] prev_fl;

  bcs_serial_compare_ctrl_if #(.WIDTH(W)) bus_ee ();
  bcs_serial_compare_ctrl_if #(.WIDTH(W)) bus_fl ();

  bcs_serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_ee (
    .clk (clk),
    .rst (rst),
    .bus (bus_ee)
  );

  bcs_serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_fl (
    .clk (clk),
    .rst (rst),
    .bus (bus_fl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slice evaluations needed with early exit: up to and including the first differing bit from the MSB.
  function automatic int ref_bits(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = W - 1; i >= 0; i--)
      if (a[i] != b[i]) return W - i;
    return W;
  endfunction

  function automatic logic [6:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b, input int bits);
    return {a == b, a > b, a < b, 4'(bits)};
  endfunction

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus_ee.start = s;
    bus_fl.start = s;
    bus_ee.a_in  = a;
    bus_fl.a_in  = a;
    bus_ee.b_in  = b;
    bus_fl.b_in  = b;
  endtask

  task automatic chk_dut(input string who, input int cyc, input int lat, input logic busy,
                         input logic done, input logic [6:0] res, input logic [6:0] old_res,
                         input logic [6:0] new_res);
    chk($sformatf("%s c%0d busy", who, cyc), 32'(busy), 32'(cyc <= lat));
    chk($sformatf("%s c%0d done", who, cyc), 32'(done), 32'(cyc == lat));
    chk($sformatf("%s c%0d result", who, cyc), 32'(res), 32'((cyc < lat) ? old_res : new_res));
  endtask

  // Start accepted at edge 0; cycle n is the negedge after edge n-1.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    int         lat_ee;
    int         lat_fl;
    logic [6:0] new_ee;
    logic [6:0] new_fl;
    lat_ee = ref_bits(a, b) + 1;
    lat_fl = W + 1;
    new_ee = ref_res(a, b, ref_bits(a, b));
    new_fl = ref_res(a, b, W);
    @(negedge clk);
    drive(1'b1, a, b);
    for (int cyc = 1; cyc <= W + 3; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        if (poke) drive(1'b1, '0, '0);
        else      drive(1'b0, W'($urandom), W'($urandom));
      end else if (cyc == 2) begin
        drive(1'b0, W'($urandom), W'($urandom));
      end
      chk_dut("ee", cyc, lat_ee, bus_ee.busy, bus_ee.done,
              {bus_ee.eq, bus_ee.gt, bus_ee.lt, bus_ee.bits_used}, prev_ee, new_ee);
      chk_dut("fl", cyc, lat_fl, bus_fl.busy, bus_fl.done,
              {bus_fl.eq, bus_fl.gt, bus_fl.lt, bus_fl.bits_used}, prev_fl, new_fl);
    end
    $display("cmp a=%02h b=%02h poke=%0d exp eq/gt/lt=%0d%0d%0d bits_ee=%0d lat_ee=%0d lat_fl=%0d",
             a, b, poke, new_ee[6], new_ee[5], new_ee[4], new_ee[3:0], lat_ee, lat_fl);
    prev_ee = new_ee;
    prev_fl = new_fl;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " ee busy"}, 32'(bus_ee.busy), 32'(0));
    chk({tag, " ee done"}, 32'(bus_ee.done), 32'(0));
    chk({tag, " ee result"}, 32'({bus_ee.eq, bus_ee.gt, bus_ee.lt, bus_ee.bits_used}), 32'(0));
    chk({tag, " fl busy"}, 32'(bus_fl.busy), 32'(0));
    chk({tag, " fl done"}, 32'(bus_fl.done), 32'(0));
    chk({tag, " fl result"}, 32'({bus_fl.eq, bus_fl.gt, bus_fl.lt, bus_fl.bits_used}), 32'(0));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst = 1'b1;
    drive(1'b0, '0, '0);
    prev_ee = '0;
    prev_fl = '0;
    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;

    run_cmp(8'hA5, 8'hA5, 1'b0);
    run_cmp(8'h80, 8'h7F, 1'b0);
    run_cmp(8'h3C, 8'h3D, 1'b0);
    run_cmp(8'h80, 8'h7F, 1'b1);

    // Abort a compare in progress with reset asserted during cycle 3.
    @(negedge clk);
    drive(1'b1, 8'h3C, 8'h3D);
    @(negedge clk);
    drive(1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("midrun ee busy", 32'(bus_ee.busy), 32'(1));
    chk("midrun fl busy", 32'(bus_fl.busy), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    chk_idle_zero("abort");
    rst = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      chk_idle_zero($sformatf("post-abort c%0d", i));
    end
    $display("abort a=3c b=3d reset mid-run, outputs cleared");
    prev_ee = '0;
    prev_fl = '0;

    run_cmp(8'h01, 8'h02, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = W'($urandom);
        1:       rb = ra;
        default: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      endcase
      run_cmp(ra, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
